del_req_sync: RTL and testbench
===============================

Name: del_req_sync

Overview:
- Clocked receiver that sits directly downstream of a delay unit.
- Takes the asynchronous 4-phase request (out_R of the delay chain) into the clock domain and presents it as a valid/ready transfer to the synchronous consumer.
- Returns the acknowledge that closes the 4-phase handshake on the delay-chain side.
- Counts completed handshakes for solver-level statistics.

Parameters:
- SYNC_STAGES, 2, number of flops in the request synchronizer (legal 2..4).
- CNT_W, 16, width of the handshake event counter.
- TIMEOUT_CYC, 255, cycles allowed in ACK for the request to return low (used only with the optional feature).

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- in_R  in  1  asynchronous request from the delay chain (out_R of the upstream delay unit); 4-phase.
- out_A  out  1  acknowledge back to the delay-chain side; registered.
- valid  out  1  request available to the synchronous consumer.
- ready  in  1  consumer accepts the request this cycle.
- busy  out  1  high in every state except IDLE.
- event_cnt  out  CNT_W  number of completed 4-phase handshakes; wraps modulo 2^CNT_W.
- err_timeout  out  1  sticky timeout flag (exists only with the optional feature).

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - out_A=0, valid=0, busy=0, event_cnt=0, err_timeout=0.
  - All synchronizer flops are 0 and the FSM is in IDLE.
- Reset asserted mid-handshake: out_A drops immediately, with no clock edge needed. After release the FSM starts in IDLE. If in_R is still high, it is treated as a new request only after the synchronized in_R has been seen low (see WAIT_LOW).
- Synchronizer: in_R passes through SYNC_STAGES flops to give r_s. Only r_s feeds logic; in_R is never used combinationally.
- FSM states (encoding in package): IDLE, OFFER, ACK, WAIT_LOW.
  - IDLE: if r_s=1, go to OFFER and set valid=1 on the next cycle.
  - OFFER: hold valid=1 until valid&ready. On that cycle, go to ACK; valid=0 and out_A=1 from the next cycle.
  - ACK: hold out_A=1 until r_s=0. Then out_A=0, event_cnt+1 (wrapping), and go to IDLE.
  - WAIT_LOW: entered only after reset when r_s=1. Go to IDLE when r_s=0. No valid, no count.
- Latency: an in_R rise that first meets setup at edge k gives valid=1 after edge k+SYNC_STAGES.
- Zero-cycle stall: if ready=1 when valid first rises, the transfer completes in that same cycle.
- Handshake rule: valid never drops without ready. Exactly one consumer transfer per in_R high phase.
- in_R glitch low during OFFER (protocol violation): ignored. The transfer still completes, and ACK then waits for r_s=0.
- No new request is accepted until the previous handshake has fully returned to zero.
- Counter wrap: at event_cnt = 2^CNT_W-1, the next completion gives 0. No flag is raised.

Optional Feature:
- Macro: DEL_REQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACK and clears on entry to ACK.
  - When it reaches TIMEOUT_CYC with r_s still 1, err_timeout is set and stays set until rst.
  - The FSM stays in ACK; the handshake is not forced.
- Undefined: no timeout counter and no err_timeout port. All other behaviour is identical.

Decomposition:
- Package del_req_pkg holds:
  - the state typedef/localparam encoding (IDLE=0, OFFER=1, ACK=2, WAIT_LOW=3);
  - default SYNC_STAGES and CNT_W constants.
- One sub-module: del_bit_sync, a parameterized SYNC_STAGES-flop synchronizer with async active-high reset to 0. It is instantiated once for in_R.

Test Plan:
- Single handshake, ready tied 1, SYNC_STAGES=2:
  - stimulus: in_R rises; later in_R falls.
  - response: valid high 2 cycles after the first sampling edge and for 1 cycle; out_A rises the next cycle; out_A falls 2–3 cycles after in_R falls; event_cnt=1.
- Back-pressure:
  - stimulus: ready=0 for 5 cycles after valid rises, then 1.
  - response: valid stays high for 6 cycles; out_A stays 0 until the accept; one transfer; event_cnt=1.
- Counter wrap:
  - stimulus: CNT_W=4, 17 handshakes.
  - response: event_cnt sequence runs up to 15, then 0, then 1.
- Reset mid-ACK:
  - stimulus: rst pulse while out_A=1 and in_R=1.
  - response: out_A=0 without a clock edge; after release, no valid while in_R stays high; valid appears only after an in_R 1→0→1 cycle.
- Glitch during OFFER:
  - stimulus: in_R low for 1 cycle, then high again, while ready=0.
  - response: valid stays high; exactly one transfer; event_cnt increments once.
- DEL_REQ_TIMEOUT_EN, TIMEOUT_CYC=10:
  - stimulus: hold in_R high after the accept.
  - response: err_timeout=1 after 10 ACK cycles; it stays 1 after in_R falls and the handshake completes; it clears only on rst.

Source files
------------

// File: rtl/del_req_pkg.sv
// del_req_pkg: shared types and defaults for the delay-chain request receiver.
// Holds the receiver FSM state encoding and default parameter values.
// Imported by del_req_sync and del_bit_sync.
package del_req_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFER    = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/del_bit_sync.sv
// del_bit_sync: SYNC_STAGES-flop single-bit synchronizer, async active-high reset to 0.
// Ports: clk, rst, d (asynchronous input), q (synchronized output).
// Latency: SYNC_STAGES clock edges from d to q.
module del_bit_sync
  import del_req_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift toward the MSB; bit 0 is the only flop that sees the async input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/del_req_sync.sv
// del_req_sync: brings the 4-phase delay-chain request into the clock domain as a
// valid/ready transfer, returns the registered acknowledge and counts completed handshakes.
// Ports: clk, rst (async, active-high), in_R (async request), out_A (ack), valid/ready
// (consumer side), busy (FSM not idle), event_cnt (completed handshakes, wrapping).
// Optional: define DEL_REQ_TIMEOUT_EN to add TIMEOUT_CYC and the sticky err_timeout output.
module del_req_sync
  import del_req_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
`ifdef DEL_REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_R,
  output logic             out_A,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic [CNT_W-1:0] event_cnt
`ifdef DEL_REQ_TIMEOUT_EN
  ,
  output logic             err_timeout
`endif
);

  // After reset the synchronizer holds 0 for SYNC_STAGES edges, so a request that was
  // already high across reset only becomes visible at edge SYNC_STAGES+1. Any request
  // seen in IDLE up to that edge is treated as left over from before reset.
  localparam int                SETTLE_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_STAGES);

  logic                r_s;
  state_t              state_q, state_d;
  logic                out_a_q, out_a_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                settling;

  del_bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (in_R),
    .q  (r_s)
  );

  assign settling = (settle_q <= SETTLE_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (r_s) state_d = settling ? WAIT_LOW : OFFER;
      // valid is high throughout OFFER, so ready alone completes the transfer. A low
      // glitch on r_s here is a protocol violation and is deliberately ignored.
      OFFER:    if (ready) state_d = ACK;
      ACK:      if (!r_s) state_d = IDLE;
      WAIT_LOW: if (!r_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    valid    = (state_q == OFFER);
    busy     = (state_q != IDLE);
    out_a_d  = (state_d == ACK);
    cnt_d    = cnt_q;
    settle_d = settling ? (settle_q + SETTLE_W'(1)) : settle_q;
    if ((state_q == ACK) && !r_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a_q  <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
    end else begin
      out_a_q  <= out_a_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  assign out_A     = out_a_q;
  assign event_cnt = cnt_q;

`ifdef DEL_REQ_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Counts ACK cycles; it is zero outside ACK so every entry to ACK starts from 0.
  // Saturates at the last count; the handshake itself is never forced.
  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (state_q == ACK) begin
      tmo_d = (tmo_q == TMO_LAST) ? tmo_q : (tmo_q + TMO_W'(1));
      if (r_s && (tmo_q == TMO_LAST)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`endif

endmodule

// File: tb/tb_del_req_sync.sv
// tb_del_req_sync: directed self-checking bench for del_req_sync (SYNC_STAGES=2, CNT_W=4).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on rising edges.
// Covers reset, single handshake, back-pressure, glitch, counter wrap and reset mid-ACK.
module tb_del_req_sync;

  localparam int CNT_W = 4;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             in_R  = 1'b0;
  logic             ready = 1'b0;
  logic             out_A;
  logic             valid;
  logic             busy;
  logic [CNT_W-1:0] event_cnt;
`ifdef DEL_REQ_TIMEOUT_EN
  logic             err_timeout;
`endif

  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  del_req_sync #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W)
`ifdef DEL_REQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(10)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_R       (in_R),
    .out_A      (out_A),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .event_cnt  (event_cnt)
`ifdef DEL_REQ_TIMEOUT_EN
    ,
    .err_timeout(err_timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full handshake starting at a falling edge with the FSM idle.
  // stall = number of rising edges with ready=0 after valid first rises.
  task automatic do_hs(input int stall, input string tag);
    in_R  = 1'b1;
    ready = (stall == 0);
    repeat (2) @(negedge clk);
    chk({tag, "_valid_early"}, valid, 1'b0);
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_valid_hold"}, valid, 1'b1);
      chk({tag, "_ack_before_accept"}, out_A, 1'b0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_ack_pre"}, out_A, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, valid, 1'b0);
    chk({tag, "_ack_rise"}, out_A, 1'b1);
    @(negedge clk);
    chk({tag, "_no_second_xfer"}, valid, 1'b0);
    chk({tag, "_ack_hold"}, out_A, 1'b1);
    in_R = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_ack_wait_low"}, out_A, 1'b1);
    chk({tag, "_cnt_before"}, event_cnt, exp_cnt);
    @(negedge clk);
    chk({tag, "_ack_fall"}, out_A, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    exp_cnt = exp_cnt + 1'b1;
    chk({tag, "_cnt"}, event_cnt, exp_cnt);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_A", out_A, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", event_cnt, 4'd0);
`ifdef DEL_REQ_TIMEOUT_EN
    chk("rst_err", err_timeout, 1'b0);
`endif
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_valid", valid, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Single handshake, ready tied high
    do_hs(0, "single");

    // Back-pressure: ready low for 5 cycles after valid rises
    do_hs(5, "bp");

    // Glitch on in_R during OFFER with ready low
    in_R  = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("gl_valid", valid, 1'b1);
    in_R = 1'b0;
    @(negedge clk);
    in_R = 1'b1;
    chk("gl_valid_keep", valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gl_valid_hold", valid, 1'b1);
      chk("gl_ack_low", out_A, 1'b0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("gl_valid_drop", valid, 1'b0);
    chk("gl_ack_rise", out_A, 1'b1);
    @(negedge clk);
    chk("gl_one_xfer", valid, 1'b0);
    chk("gl_ack_hold", out_A, 1'b1);
    in_R = 1'b0;
    repeat (2) @(negedge clk);
    chk("gl_ack_wait", out_A, 1'b1);
    @(negedge clk);
    chk("gl_ack_fall", out_A, 1'b0);
    exp_cnt = exp_cnt + 1'b1;
    chk("gl_cnt", event_cnt, exp_cnt);
    ready = 1'b0;

    // Counter wrap: 17 handshakes carry the 4-bit count through 15 -> 0
    for (int n = 0; n < 17; n++) begin
      do_hs(0, "wrap");
    end
    chk("wrap_final", event_cnt, 4'd4);

    // Reset mid-ACK with in_R held high
    in_R  = 1'b1;
    ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_ack_before", out_A, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mr_ack_async", out_A, 1'b0);
    chk("mr_valid", valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_cnt", event_cnt, 4'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_valid", valid, 1'b0);
      chk("mr_no_ack", out_A, 1'b0);
    end
    chk("mr_wait_low", busy, 1'b1);
    in_R = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_back_idle", busy, 1'b0);
    chk("mr_cnt_kept", event_cnt, 4'd0);
    do_hs(0, "mr_new");

`ifdef DEL_REQ_TIMEOUT_EN
    // Timeout: in_R held high in ACK for more than 10 cycles
    in_R  = 1'b1;
    ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_ack", out_A, 1'b1);
    repeat (9) @(negedge clk);
    chk("to_err_early", err_timeout, 1'b0);
    @(negedge clk);
    chk("to_err_set", err_timeout, 1'b1);
    chk("to_still_ack", out_A, 1'b1);
    in_R = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_ack_fall", out_A, 1'b0);
    chk("to_err_sticky", err_timeout, 1'b1);
    exp_cnt = exp_cnt + 1'b1;
    chk("to_cnt", event_cnt, exp_cnt);
    rst = 1'b1;
    @(negedge clk);
    chk("to_err_clear", err_timeout, 1'b0);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
